// File: rtl/assoc_sweep_checker.sv
// Exhaustive associativity checker: sweeps every N x W-bit operand vector and
// compares a left fold against a right fold of the selected bitwise operator.
module assoc_sweep_checker #(
    parameter int N = 3,
    parameter int W = 1,
    localparam int TOTAL = N * W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [TOTAL:0]   mismatch_count,
    output logic [TOTAL-1:0] first_vec,
    output logic [TOTAL-1:0] cur_vec
);

    generate
        if (N < 2 || N > 8 || TOTAL < 2 || TOTAL > 20) begin : g_param_check
            $error("assoc_sweep_checker: N must be 2..8 and N*W must be 2..20");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [1:0]       op_q;
    logic [1:0]       drain_cnt;
    logic             vld_p1;
    logic [W-1:0]     left_p1;
    logic [W-1:0]     right_p1;
    logic [TOTAL-1:0] vec_p1;

    function automatic logic [W-1:0] apply_op(input logic [1:0] sel,
                                              input logic [W-1:0] a,
                                              input logic [W-1:0] b);
        case (sel)
            2'b00:   apply_op = a | b;
            2'b01:   apply_op = a & b;
            2'b10:   apply_op = a ^ b;
            default: apply_op = ~(a & b);
        endcase
    endfunction

    // x0 sits in the MSBs, so operand k starts at bit TOTAL-1-k*W.
    function automatic logic [W-1:0] fold_left(input logic [1:0] sel,
                                               input logic [TOTAL-1:0] v);
        logic [W-1:0] acc;
        acc = v[TOTAL-1 -: W];
        for (int k = 1; k < N; k++)
            acc = apply_op(sel, acc, v[TOTAL-1-k*W -: W]);
        return acc;
    endfunction

    function automatic logic [W-1:0] fold_right(input logic [1:0] sel,
                                                input logic [TOTAL-1:0] v);
        logic [W-1:0] acc;
        acc = v[W-1:0];
        for (int k = N - 2; k >= 0; k--)
            acc = apply_op(sel, v[TOTAL-1-k*W -: W], acc);
        return acc;
    endfunction

    // Stage 1: fold results and the vector that produced them
    always_ff @(posedge clk) begin
        left_p1  <= fold_left(op_q, cur_vec);
        right_p1 <= fold_right(op_q, cur_vec);
        vec_p1   <= cur_vec;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            op_q           <= 2'b00;
            drain_cnt      <= 2'd0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass           <= 1'b0;
            cur_vec        <= '0;
            vld_p1         <= 1'b0;
            mismatch_count <= '0;
            first_vec      <= '0;
        end else begin
            vld_p1 <= (state == RUN);
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state          <= RUN;
                        op_q           <= op;
                        busy           <= 1'b1;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        cur_vec        <= '0;
                        mismatch_count <= '0;
                        first_vec      <= '0;
                    end
                end
                RUN: begin
                    if (cur_vec == '1) begin
                        state     <= DRAIN;
                        drain_cnt <= 2'd0;
                    end else begin
                        cur_vec <= cur_vec + 1'b1;
                    end
                end
                DRAIN: begin
                    // The final vector is counted inside this window, so the
                    // count is settled by the time pass is sampled.
                    if (drain_cnt == 2'd2) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (mismatch_count == '0);
                    end else begin
                        drain_cnt <= drain_cnt + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // Stage 2: tally mismatches, remembering the first offender
            if (vld_p1 && (left_p1 != right_p1)) begin
                mismatch_count <= mismatch_count + 1'b1;
                if (mismatch_count == '0)
                    first_vec <= vec_p1;
            end
        end
    end

endmodule

// File: tb/tb_assoc_sweep_checker.sv
// Bench for assoc_sweep_checker: table-driven sweeps on N=3,W=1 and N=4,W=2
// instances plus directed restart, mid-sweep reset and busy-start sequences.
module tb_assoc_sweep_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       start3, start4;
    logic [1:0] op3, op4;

    logic       busy3, done3, pass3;
    logic [3:0] count3;
    logic [2:0] first3, cur3;
    logic       busy4, done4, pass4;
    logic [8:0] count4;
    logic [7:0] first4, cur4;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assoc_sweep_checker #(.N(3), .W(1)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .op(op3),
        .busy(busy3), .done(done3), .pass(pass3),
        .mismatch_count(count3), .first_vec(first3), .cur_vec(cur3)
    );

    assoc_sweep_checker #(.N(4), .W(2)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .op(op4),
        .busy(busy4), .done(done4), .pass(pass4),
        .mismatch_count(count4), .first_vec(first4), .cur_vec(cur4)
    );

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    function automatic logic [1:0] op2(input logic [1:0] o, input logic [1:0] a,
                                       input logic [1:0] b);
        case (o)
            2'b00:   op2 = a | b;
            2'b01:   op2 = a & b;
            2'b10:   op2 = a ^ b;
            default: op2 = ~(a & b);
        endcase
    endfunction

    // Reference for N=4, W=2: folds written from the operand list directly.
    task automatic model4(input logic [1:0] o, output int cnt, output int first);
        logic [7:0] vv;
        logic [1:0] x [4];
        logic [1:0] l, r;
        cnt = 0;
        first = 0;
        for (int v = 0; v < 256; v++) begin
            vv = v[7:0];
            x[0] = vv[7:6]; x[1] = vv[5:4]; x[2] = vv[3:2]; x[3] = vv[1:0];
            l = op2(o, op2(o, op2(o, x[0], x[1]), x[2]), x[3]);
            r = op2(o, x[0], op2(o, x[1], op2(o, x[2], x[3])));
            if (l != r) begin
                if (cnt == 0) first = v;
                cnt++;
            end
        end
    endtask

    // Starts a sweep on the chosen instance and counts edges until done.
    task automatic run(input bit big, input logic [1:0] o, output int edges);
        @(negedge clk);
        if (big) begin op4 = o; start4 = 1'b1; end
        else     begin op3 = o; start3 = 1'b1; end
        @(posedge clk);
        #1;
        start3 = 1'b0;
        start4 = 1'b0;
        edges = 0;
        check(big ? "done_drop4" : "done_drop3", big ? done4 : done3, 0);
        check(big ? "busy_start4" : "busy_start3", big ? busy4 : busy3, 1);
        while (!(big ? done4 : done3) && edges < 2000) begin
            @(posedge clk);
            edges++;
            #1;
        end
    endtask

    typedef struct {
        logic [1:0] op;
        int         cnt;
        int         first;
        int         pass_e;
    } vec_t;

    vec_t tbl[4];
    logic [1:0] ops4[4];
    int edges, mcnt, mfirst;

    initial begin
        tbl[0] = '{op: 2'b00, cnt: 0, first: 0, pass_e: 1};
        tbl[1] = '{op: 2'b11, cnt: 4, first: 1, pass_e: 0};
        tbl[2] = '{op: 2'b10, cnt: 0, first: 0, pass_e: 1};
        tbl[3] = '{op: 2'b01, cnt: 0, first: 0, pass_e: 1};
        ops4[0] = 2'b01; ops4[1] = 2'b11; ops4[2] = 2'b10; ops4[3] = 2'b00;

        rst = 1'b1; start3 = 1'b0; start4 = 1'b0; op3 = 2'b00; op4 = 2'b00;
        #1;
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_pass", pass3, 0);
        check("rst_count", count3, 0);
        check("rst_first", first3, 0);
        check("rst_cur", cur3, 0);
        check("rst_done4", done4, 0);
        @(negedge clk);
        rst = 1'b0;

        // Successive entries restart from DONE, covering back-to-back runs.
        for (int i = 0; i < 4; i++) begin
            run(1'b0, tbl[i].op, edges);
            check("lat3", edges, 11);
            check("count3", count3, tbl[i].cnt);
            check("first3", first3, tbl[i].first);
            check("pass3", pass3, tbl[i].pass_e);
            check("busy_end3", busy3, 0);
            check("cur_end3", cur3, 7);
        end

        repeat (3) @(posedge clk);
        #1;
        check("done_hold", done3, 1);
        check("pass_hold", pass3, 1);

        for (int i = 0; i < 4; i++) begin
            model4(ops4[i], mcnt, mfirst);
            run(1'b1, ops4[i], edges);
            check("lat4", edges, 259);
            check("count4", count4, mcnt);
            check("first4", first4, mfirst);
            check("pass4", pass4, (mcnt == 0) ? 1 : 0);
        end

        // Reset during a NAND sweep clears everything without waiting for an edge.
        @(negedge clk);
        op3 = 2'b11; start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_busy", busy3, 0);
        check("mid_rst_done", done3, 0);
        check("mid_rst_count", count3, 0);
        check("mid_rst_first", first3, 0);
        check("mid_rst_cur", cur3, 0);
        check("mid_rst_done4", done4, 0);
        @(negedge clk);
        rst = 1'b0;
        run(1'b0, 2'b11, edges);
        check("post_rst_lat", edges, 11);
        check("post_rst_count", count3, 4);
        check("post_rst_first", first3, 1);

        // A start pulse and an op change while busy must not disturb the sweep.
        @(negedge clk);
        op3 = 2'b11; start3 = 1'b1;
        @(posedge clk);
        #1 start3 = 1'b0;
        edges = 0;
        repeat (3) begin
            @(posedge clk);
            edges++;
        end
        #1 op3 = 2'b00; start3 = 1'b1;
        @(posedge clk);
        edges++;
        #1 start3 = 1'b0;
        check("busy_mid", busy3, 1);
        while (!done3 && edges < 100) begin
            @(posedge clk);
            edges++;
            #1;
        end
        check("busy_start_lat", edges, 11);
        check("busy_start_count", count3, 4);
        check("busy_start_first", first3, 1);
        check("busy_start_pass", pass3, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
